stream_rr_arb: RTL and testbench

- Round-robin scheduler that shares one downstream stream consumer (e.g. a generated map/dup pipeline) between N upstream requester streams.
- Grants one requester at a time. A grant is held for bursts of up to MAX_BURST beats, then rotates.
- Each accepted beat is registered into a single-entry output stage, tagged with the requester index so results can be routed back.
- Sits between generated stream producers and a shared stream-processing module; valid/ready handshake throughout.

---
 rtl/stream_rr_arb_pkg.sv | 28 ++
 rtl/stream_rr_arb_rr_pick.sv | 44 ++++
 rtl/stream_rr_arb.sv | 121 ++++++++++++
 tb/tb_stream_rr_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arb_pkg.sv
// Shared constants and types for the round-robin stream arbiter.
package stream_rr_arb_pkg;

    localparam int unsigned INTN_W = 8;
    localparam bit          TRUE   = 1'b1;
    localparam bit          FALSE  = 1'b0;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    typedef struct packed {
        logic [2:0]        tag;
        logic [INTN_W-1:0] data;
    } beat_t;

    // Smallest tag width able to index n requesters (never below 1).
    function automatic int unsigned tag_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_rr_arb_rr_pick.sv
// Combinational round-robin picker: optional hold on the start index, else a wrap scan
// beginning just after it and ending on the start index itself.
module rr_pick
    import stream_rr_arb_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned TAG_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [TAG_W-1:0] i_start,
    input  logic             i_hold,
    output logic [TAG_W-1:0] o_g,
    output logic             o_gv
);

    int unsigned w_best;
    int unsigned w_dist;

    // Distance from the start index ranks candidates; the start index itself ranks last
    // unless held, in which case it ranks first.
    always_comb begin
        o_g    = '0;
        o_gv   = FALSE;
        w_best = N + 1;
        w_dist = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_req[i]) begin
                w_dist = (i + N - 32'(i_start)) % N;
                if (w_dist == 0) begin
                    w_dist = N;
                end
                if (i_hold && (i == 32'(i_start))) begin
                    w_dist = 0;
                end
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    o_g    = TAG_W'(i);
                    o_gv   = TRUE;
                end
            end
        end
    end

endmodule

// File: rtl/stream_rr_arb.sv
// Round-robin arbiter sharing one downstream stream among N requesters, with bounded
// bursts and a single registered output stage tagged by requester index.
module stream_rr_arb
    import stream_rr_arb_pkg::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned W         = INTN_W,
    parameter int unsigned TAG_W     = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [TAG_W-1:0] r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    lock_e            r_lock, w_lock_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [W-1:0]     r_out_data, w_out_data_nxt;
    logic [TAG_W-1:0] r_out_tag, w_out_tag_nxt;

    logic             w_hold;
    logic [TAG_W-1:0] w_g;
    logic             w_gv;
    logic             w_can_accept;
    logic             w_xfer;
    logic             w_owner_valid;
    logic [W-1:0]     w_gdata;

    assign w_hold       = (r_lock == LOCKED) && (r_cnt < CNT_W'(MAX_BURST));
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_xfer       = w_gv && w_can_accept && !rst;

    rr_pick #(
        .N     (N),
        .TAG_W (TAG_W)
    ) u_pick (
        .i_req   (in_valid),
        .i_start (r_owner),
        .i_hold  (w_hold),
        .o_g     (w_g),
        .o_gv    (w_gv)
    );

    always_comb begin
        in_ready      = '0;
        w_gdata       = '0;
        w_owner_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_g == TAG_W'(i)) begin
                in_ready[i] = w_xfer;
                w_gdata     = in_data[i*W +: W];
            end
            if (r_owner == TAG_W'(i)) begin
                w_owner_valid = in_valid[i];
            end
        end
    end

    // Continuing the burst requires the hold to still be active; a wrap-scan regrant of
    // the owner after the burst limit restarts the count instead of overrunning it.
    always_comb begin
        w_owner_nxt     = r_owner;
        w_cnt_nxt       = r_cnt;
        w_lock_nxt      = r_lock;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_tag_nxt   = r_out_tag;
        if (w_xfer) begin
            w_out_data_nxt  = w_gdata;
            w_out_tag_nxt   = w_g;
            w_out_valid_nxt = 1'b1;
            if (w_hold && (w_g == r_owner)) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
                w_owner_nxt = w_g;
                w_cnt_nxt   = CNT_W'(1);
                w_lock_nxt  = LOCKED;
            end
        end else begin
            if (r_out_valid && out_ready) begin
                w_out_valid_nxt = 1'b0;
            end
            if ((r_lock == LOCKED) && !w_owner_valid) begin
                w_lock_nxt = UNLOCKED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= TAG_W'(N - 1);
            r_cnt       <= '0;
            r_lock      <= UNLOCKED;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lock      <= w_lock_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_tag   <= w_out_tag_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_stream_rr_arb.sv
// Scoreboard bench for stream_rr_arb (N=2, W=8, MAX_BURST=4).
module tb_stream_rr_arb;
    import stream_rr_arb_pkg::*;

    localparam int unsigned N     = 2;
    localparam int unsigned W     = 8;
    localparam int unsigned TAG_W = tag_width(N);

    logic             clk;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [N*W-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    logic [W-1:0]       src0[$];
    logic [W-1:0]       src1[$];
    logic [TAG_W+W-1:0] sb[$];

    int n_vec;
    int n_err;

    stream_rr_arb #(
        .N         (N),
        .W         (W),
        .TAG_W     (TAG_W),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        in_valid[0]     = (src0.size() > 0);
        in_valid[1]     = (src1.size() > 0);
        in_data[0 +: W] = (src0.size() > 0) ? src0[0] : '0;
        in_data[W +: W] = (src1.size() > 0) ? src1[0] : '0;
    endtask

    task automatic expect_beat(input logic [TAG_W-1:0] tag, input logic [W-1:0] data);
        sb.push_back({tag, data});
    endtask

    // One cycle: sample handshakes before the posedge, then update sources at the negedge.
    task automatic step();
        logic [N-1:0]       acc;
        logic [TAG_W+W-1:0] exp_b;
        #1;
        acc = in_valid & in_ready;
        if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL out_beat: got tag=%0d data=%h, required no beat", out_tag, out_data);
            end else begin
                exp_b = sb.pop_front();
                if ({out_tag, out_data} !== exp_b) begin
                    n_err++;
                    $display("FAIL out_beat: got tag=%0d data=%h, required tag=%0d data=%h",
                             out_tag, out_data, exp_b[W +: TAG_W], exp_b[W-1:0]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (acc[0]) void'(src0.pop_front());
        if (acc[1]) void'(src1.pop_front());
        drive();
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d beats still expected, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        src0.delete();
        src1.delete();
        sb.delete();
        out_ready = 1'b1;
        drive();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_steps(input string name, input int got, input int req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0d cycles, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        rst = 1'b1;
        src0.delete();
        src1.delete();
        sb.delete();
        src0.push_back(8'hA0);
        src1.push_back(8'hB0);
        out_ready = 1'b1;
        drive();
        #1;
        n_vec += 4;
        if (in_ready !== 2'b00) begin n_err++; $display("FAIL rst_in_ready: got %b, required 00", in_ready); end
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h, required 00", out_data); end
        if (out_tag !== 1'b0)   begin n_err++; $display("FAIL rst_out_tag: got %0d, required 0", out_tag); end
        @(negedge clk);
        rst = 1'b0;
        expect_beat(1'b0, 8'hA0);
        expect_beat(1'b1, 8'hB0);
        drain(20, n);
        check_steps("reset_first_grant_cycles", n, 3);
    endtask

    task automatic test_single();
        int n;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            src0.push_back(8'(i));
            expect_beat(1'b0, 8'(i));
        end
        drive();
        drain(40, n);
        check_steps("single_no_bubble_cycles", n, 11);
    endtask

    task automatic test_contention();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            src0.push_back(8'h10 + 8'(i));
            src1.push_back(8'h20 + 8'(i));
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) expect_beat(1'b0, 8'h10 + 8'(b*4 + i));
            for (int i = 0; i < 4; i++) expect_beat(1'b1, 8'h20 + 8'(b*4 + i));
        end
        drive();
        drain(60, n);
        check_steps("contention_cycles", n, 17);
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            src0.push_back(8'h10 + 8'(i));
            expect_beat(1'b0, 8'h10 + 8'(i));
        end
        drive();
        repeat (3) step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec += 3;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b, required 1", out_valid); end
            if (out_data !== 8'h12) begin n_err++; $display("FAIL stall_data: got %h, required 12", out_data); end
            if (in_ready !== 2'b00) begin n_err++; $display("FAIL stall_in_ready: got %b, required 00", in_ready); end
            step();
        end
        out_ready = 1'b1;
        drain(30, n);
        check_steps("backpressure_resume_cycles", n, 4);
    endtask

    task automatic test_early_release();
        int n;
        do_reset();
        src0.push_back(8'h30);
        src0.push_back(8'h31);
        for (int i = 0; i < 5; i++) src1.push_back(8'h40 + 8'(i));
        expect_beat(1'b0, 8'h30);
        expect_beat(1'b0, 8'h31);
        for (int i = 0; i < 4; i++) expect_beat(1'b1, 8'h40 + 8'(i));
        expect_beat(1'b0, 8'h32);
        expect_beat(1'b0, 8'h33);
        expect_beat(1'b1, 8'h44);
        drive();
        repeat (3) step();
        src0.push_back(8'h32);
        src0.push_back(8'h33);
        drive();
        drain(40, n);
        check_steps("early_release_cycles", n + 3, 10);
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            src1.push_back(8'h60 + 8'(i));
            expect_beat(1'b1, 8'h60 + 8'(i));
        end
        drive();
        repeat (2) step();
        #1;
        rst = 1'b1;
        #1;
        n_vec += 2;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b, required 0", out_valid); end
        if (in_ready !== 2'b00) begin n_err++; $display("FAIL async_rst_in_ready: got %b, required 00", in_ready); end
        rst = 1'b0;
        src0.delete();
        src1.delete();
        sb.delete();
        src0.push_back(8'h50);
        src0.push_back(8'h51);
        src1.push_back(8'h70);
        src1.push_back(8'h71);
        expect_beat(1'b0, 8'h50);
        expect_beat(1'b0, 8'h51);
        expect_beat(1'b1, 8'h70);
        expect_beat(1'b1, 8'h71);
        drive();
        drain(30, n);
        check_steps("async_reset_restart_cycles", n, 5);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
